// File: rtl/memoria_dados_param.sv
// Parametrised single-port data memory: registered write-first read, range check, busy flag.
// Optional post-reset zeroing sweep is enabled by defining MEMORIA_DADOS_LIMPEZA_EN.
module memoria_dados_param #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 8,
    parameter int LARGURA_END  = $clog2(PROFUNDIDADE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LARGURA_END-1:0] endereco,
    input  logic [LARGURA-1:0]     valor_escrita,
    input  logic                   leitura,
    input  logic                   escrita,
    output logic [LARGURA-1:0]     valor_saida,
    output logic                   saida_valida,
    output logic                   ocupado,
    output logic                   erro_endereco
);

    typedef enum logic {
        LIMPANDO,
        PRONTO
    } estado_t;

    localparam logic [LARGURA_END:0] PROF_EXT = (LARGURA_END+1)'(PROFUNDIDADE);

    estado_t                estado_q;
    logic [LARGURA-1:0]     mem [PROFUNDIDADE];
    logic [LARGURA-1:0]     valor_q;
    logic                   valida_q;
    logic                   ocupado_q;
    logic                   erro_q;

    logic                   aceito;
    logic                   noIntervalo;
    logic [LARGURA_END-1:0] idxLeitura;
    logic                   memWe_d;
    logic [LARGURA_END-1:0] memEnd_d;
    logic [LARGURA-1:0]     memDado_d;

`ifdef MEMORIA_DADOS_LIMPEZA_EN
    localparam logic [LARGURA_END-1:0] CONT_MAX = LARGURA_END'(PROFUNDIDADE-1);
    logic [LARGURA_END-1:0] cont_q;
`endif

    // The clamped read index keeps the array lookup in bounds for non-power-of-two depths.
    always_comb begin
        aceito      = reset && (estado_q == PRONTO);
        noIntervalo = ({1'b0, endereco} < PROF_EXT);
        idxLeitura  = noIntervalo ? endereco : '0;
        memWe_d     = aceito && escrita && noIntervalo;
        memEnd_d    = endereco;
        memDado_d   = valor_escrita;
`ifdef MEMORIA_DADOS_LIMPEZA_EN
        if (reset && (estado_q == LIMPANDO)) begin
            memWe_d   = 1'b1;
            memEnd_d  = cont_q;
            memDado_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (memWe_d) begin
            mem[memEnd_d] <= memDado_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q  <= LIMPANDO;
            valor_q   <= '0;
            valida_q  <= 1'b0;
            erro_q    <= 1'b0;
            ocupado_q <= 1'b1;
`ifdef MEMORIA_DADOS_LIMPEZA_EN
            cont_q    <= '0;
`endif
        end else begin
            case (estado_q)
                LIMPANDO: begin
                    valida_q <= 1'b0;
                    erro_q   <= 1'b0;
`ifdef MEMORIA_DADOS_LIMPEZA_EN
                    if (cont_q == CONT_MAX) begin
                        estado_q  <= PRONTO;
                        ocupado_q <= 1'b0;
                    end else begin
                        cont_q <= cont_q + 1'b1;
                    end
`else
                    estado_q  <= PRONTO;
                    ocupado_q <= 1'b0;
`endif
                end
                PRONTO: begin
                    // Single address port, so a simultaneous write always targets the read word.
                    if (leitura) begin
                        if (!noIntervalo) begin
                            valor_q <= '0;
                        end else if (escrita) begin
                            valor_q <= valor_escrita;
                        end else begin
                            valor_q <= mem[idxLeitura];
                        end
                    end
                    valida_q  <= leitura;
                    erro_q    <= (leitura || escrita) && !noIntervalo;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q  <= LIMPANDO;
                    ocupado_q <= 1'b1;
                end
            endcase
        end
    end

    assign valor_saida   = valor_q;
    assign saida_valida  = valida_q;
    assign ocupado       = ocupado_q;
    assign erro_endereco = erro_q;

endmodule

// File: tb/tb_memoria_dados_param.sv
// Directed bench for memoria_dados_param: an 8-deep instance and a 6-deep instance for range checks.
// Expected sweep length and post-reset contents follow MEMORIA_DADOS_LIMPEZA_EN.
module tb_memoria_dados_param;

`ifdef MEMORIA_DADOS_LIMPEZA_EN
    localparam bit LIMPEZA = 1'b1;
`else
    localparam bit LIMPEZA = 1'b0;
`endif
    localparam int SWEEP  = LIMPEZA ? 8 : 1;
    localparam int SWEEP2 = LIMPEZA ? 6 : 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] endereco = '0;
    logic [7:0] valor_escrita = '0;
    logic       leitura = 1'b0;
    logic       escrita = 1'b0;
    logic [7:0] valor_saida;
    logic       saida_valida;
    logic       ocupado;
    logic       erro_endereco;

    logic       reset2 = 1'b0;
    logic [2:0] endereco2 = '0;
    logic [7:0] valor_escrita2 = '0;
    logic       leitura2 = 1'b0;
    logic       escrita2 = 1'b0;
    logic [7:0] valor_saida2;
    logic       saida_valida2;
    logic       ocupado2;
    logic       erro_endereco2;

    int asserts = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memoria_dados_param #(.LARGURA(8), .PROFUNDIDADE(8)) dut (
        .clk(clk), .reset(reset), .endereco(endereco), .valor_escrita(valor_escrita),
        .leitura(leitura), .escrita(escrita), .valor_saida(valor_saida),
        .saida_valida(saida_valida), .ocupado(ocupado), .erro_endereco(erro_endereco)
    );

    memoria_dados_param #(.LARGURA(8), .PROFUNDIDADE(6)) dut6 (
        .clk(clk), .reset(reset2), .endereco(endereco2), .valor_escrita(valor_escrita2),
        .leitura(leitura2), .escrita(escrita2), .valor_saida(valor_saida2),
        .saida_valida(saida_valida2), .ocupado(ocupado2), .erro_endereco(erro_endereco2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] a, input logic [7:0] d);
        leitura = rd;
        escrita = wr;
        endereco = a;
        valor_escrita = d;
    endtask

    task automatic applyStimulus6(input bit rd, input bit wr, input logic [2:0] a, input logic [7:0] d);
        leitura2 = rd;
        escrita2 = wr;
        endereco2 = a;
        valor_escrita2 = d;
    endtask

    // Counts edges after reset release until the busy flag drops, bounded.
    task automatic waitReady(input bit second, output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n++;
            if (second ? !ocupado2 : !ocupado) break;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 8'h00);
        tick();
        tick();
        asserts++; if (valor_saida !== 8'h00) begin failures++; $display("[TB] FAIL reset_valor: got %h expected 00", valor_saida); end
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL reset_valida: got %b expected 0", saida_valida); end
        asserts++; if (erro_endereco !== 1'b0) begin failures++; $display("[TB] FAIL reset_erro: got %b expected 0", erro_endereco); end
        asserts++; if (ocupado !== 1'b1) begin failures++; $display("[TB] FAIL reset_ocupado: got %b expected 1", ocupado); end
        reset = 1'b1;
        waitReady(1'b0, n);
        asserts++; if (n !== SWEEP) begin failures++; $display("[TB] FAIL reset_sweep_len: got %0d expected %0d", n, SWEEP); end
    endtask

    task automatic test_write_read();
        applyStimulus(0, 1, 3'd1, 8'hAA);
        tick();
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL wr_only_valida: got %b expected 0", saida_valida); end
        applyStimulus(1, 0, 3'd1, 8'h00);
        tick();
        asserts++; if (valor_saida !== 8'hAA) begin failures++; $display("[TB] FAIL wr_rd_valor: got %h expected aa", valor_saida); end
        asserts++; if (saida_valida !== 1'b1) begin failures++; $display("[TB] FAIL wr_rd_valida: got %b expected 1", saida_valida); end
        asserts++; if (erro_endereco !== 1'b0) begin failures++; $display("[TB] FAIL wr_rd_erro: got %b expected 0", erro_endereco); end
        applyStimulus(0, 0, 3'd0, 8'h00);
        tick();
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL wr_rd_pulse_end: got %b expected 0", saida_valida); end
        asserts++; if (valor_saida !== 8'hAA) begin failures++; $display("[TB] FAIL wr_rd_hold: got %h expected aa", valor_saida); end
    endtask

    task automatic test_read_during_write();
        applyStimulus(1, 1, 3'd3, 8'h5C);
        tick();
        asserts++; if (valor_saida !== 8'h5C) begin failures++; $display("[TB] FAIL rdw_same: got %h expected 5c", valor_saida); end
        asserts++; if (saida_valida !== 1'b1) begin failures++; $display("[TB] FAIL rdw_valida: got %b expected 1", saida_valida); end
        applyStimulus(0, 1, 3'd4, 8'h11);
        tick();
        applyStimulus(1, 0, 3'd3, 8'h00);
        tick();
        asserts++; if (valor_saida !== 8'h5C) begin failures++; $display("[TB] FAIL rdw_other_addr: got %h expected 5c", valor_saida); end
        applyStimulus(1, 0, 3'd4, 8'h00);
        tick();
        asserts++; if (valor_saida !== 8'h11) begin failures++; $display("[TB] FAIL rdw_addr4: got %h expected 11", valor_saida); end
        applyStimulus(0, 0, 3'd0, 8'h00);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] addrs [3];
        logic [7:0] exp [3];
        addrs = '{3'd1, 3'd3, 3'd4};
        exp   = '{8'hAA, 8'h5C, 8'h11};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, addrs[i], 8'h00);
            tick();
            asserts++; if (valor_saida !== exp[i]) begin failures++; $display("[TB] FAIL b2b_valor[%0d]: got %h expected %h", i, valor_saida, exp[i]); end
            asserts++; if (saida_valida !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valida[%0d]: got %b expected 1", i, saida_valida); end
        end
        applyStimulus(0, 0, 3'd0, 8'h00);
        tick();
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end: got %b expected 0", saida_valida); end
    endtask

    task automatic test_sweep_zeroing();
        int n;
        logic [7:0] expv;
        expv = LIMPEZA ? 8'h00 : 8'h77;
        applyStimulus(0, 1, 3'd5, 8'h77);
        tick();
        applyStimulus(0, 0, 3'd0, 8'h00);
        reset = 1'b0;
        tick();
        tick();
        asserts++; if (ocupado !== 1'b1) begin failures++; $display("[TB] FAIL sweep_ocupado_rst: got %b expected 1", ocupado); end
        reset = 1'b1;
        waitReady(1'b0, n);
        asserts++; if (n !== SWEEP) begin failures++; $display("[TB] FAIL sweep_len: got %0d expected %0d", n, SWEEP); end
        applyStimulus(1, 0, 3'd5, 8'h00);
        tick();
        asserts++; if (valor_saida !== expv) begin failures++; $display("[TB] FAIL sweep_zero: got %h expected %h", valor_saida, expv); end
        asserts++; if (saida_valida !== 1'b1) begin failures++; $display("[TB] FAIL sweep_rd_valida: got %b expected 1", saida_valida); end
        applyStimulus(0, 0, 3'd0, 8'h00);
        tick();
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL sweep_rd_pulse: got %b expected 0", saida_valida); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        logic [7:0] expv;
        expv = LIMPEZA ? 8'h00 : 8'h9E;
        applyStimulus(0, 1, 3'd2, 8'h9E);
        tick();
        applyStimulus(1, 0, 3'd2, 8'h00);
        tick();
        asserts++; if (valor_saida !== 8'h9E) begin failures++; $display("[TB] FAIL mid_pre_valor: got %h expected 9e", valor_saida); end
        applyStimulus(0, 0, 3'd0, 8'h00);
        reset = 1'b0;
        tick();
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL mid_valida_clr: got %b expected 0", saida_valida); end
        asserts++; if (valor_saida !== 8'h00) begin failures++; $display("[TB] FAIL mid_valor_clr: got %h expected 00", valor_saida); end
        reset = 1'b1;
        applyStimulus(1, 1, 3'd2, 8'h33);
        tick();
        asserts++; if (saida_valida !== 1'b0) begin failures++; $display("[TB] FAIL mid_ignored_valida: got %b expected 0", saida_valida); end
        asserts++; if (erro_endereco !== 1'b0) begin failures++; $display("[TB] FAIL mid_ignored_erro: got %b expected 0", erro_endereco); end
        applyStimulus(0, 0, 3'd0, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        tick();
        asserts++; if (ocupado !== 1'b1) begin failures++; $display("[TB] FAIL mid_ocupado: got %b expected 1", ocupado); end
        reset = 1'b1;
        waitReady(1'b0, n);
        asserts++; if (n !== SWEEP) begin failures++; $display("[TB] FAIL mid_restart_len: got %0d expected %0d", n, SWEEP); end
        applyStimulus(1, 0, 3'd2, 8'h00);
        tick();
        asserts++; if (valor_saida !== expv) begin failures++; $display("[TB] FAIL mid_dropped_write: got %h expected %h", valor_saida, expv); end
        asserts++; if (saida_valida !== 1'b1) begin failures++; $display("[TB] FAIL mid_rd_valida: got %b expected 1", saida_valida); end
        applyStimulus(0, 0, 3'd0, 8'h00);
        tick();
    endtask

    task automatic test_range();
        int n;
        reset2 = 1'b0;
        applyStimulus6(0, 0, 3'd0, 8'h00);
        tick();
        tick();
        reset2 = 1'b1;
        waitReady(1'b1, n);
        asserts++; if (n !== SWEEP2) begin failures++; $display("[TB] FAIL range_sweep_len: got %0d expected %0d", n, SWEEP2); end
        applyStimulus6(0, 1, 3'd7, 8'hFF);
        tick();
        asserts++; if (erro_endereco2 !== 1'b1) begin failures++; $display("[TB] FAIL range_wr_erro: got %b expected 1", erro_endereco2); end
        asserts++; if (saida_valida2 !== 1'b0) begin failures++; $display("[TB] FAIL range_wr_valida: got %b expected 0", saida_valida2); end
        applyStimulus6(0, 1, 3'd5, 8'h42);
        tick();
        asserts++; if (erro_endereco2 !== 1'b0) begin failures++; $display("[TB] FAIL range_wr5_erro: got %b expected 0", erro_endereco2); end
        applyStimulus6(1, 0, 3'd7, 8'h00);
        tick();
        asserts++; if (valor_saida2 !== 8'h00) begin failures++; $display("[TB] FAIL range_rd_valor: got %h expected 00", valor_saida2); end
        asserts++; if (saida_valida2 !== 1'b1) begin failures++; $display("[TB] FAIL range_rd_valida: got %b expected 1", saida_valida2); end
        asserts++; if (erro_endereco2 !== 1'b1) begin failures++; $display("[TB] FAIL range_rd_erro: got %b expected 1", erro_endereco2); end
        applyStimulus6(1, 0, 3'd5, 8'h00);
        tick();
        asserts++; if (valor_saida2 !== 8'h42) begin failures++; $display("[TB] FAIL range_rd5_valor: got %h expected 42", valor_saida2); end
        asserts++; if (erro_endereco2 !== 1'b0) begin failures++; $display("[TB] FAIL range_rd5_erro: got %b expected 0", erro_endereco2); end
        applyStimulus6(1, 1, 3'd6, 8'h99);
        tick();
        asserts++; if (erro_endereco2 !== 1'b1) begin failures++; $display("[TB] FAIL range_rdwr_erro: got %b expected 1", erro_endereco2); end
        asserts++; if (valor_saida2 !== 8'h00) begin failures++; $display("[TB] FAIL range_rdwr_valor: got %h expected 00", valor_saida2); end
        applyStimulus6(0, 0, 3'd0, 8'h00);
        tick();
        asserts++; if (erro_endereco2 !== 1'b0) begin failures++; $display("[TB] FAIL range_erro_pulse: got %b expected 0", erro_endereco2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_during_write();
        test_back_to_back();
        test_sweep_zeroing();
        test_reset_mid_sweep();
        test_range();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
